// File: rtl/fb_scanout.sv
// VGA scan-out for the shared RGB565 framebuffer: raster counters, read-address counter,
// latency-matched sync/data-enable pipeline and a registered 12-bit RGB output stage.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [18:0] fb_addr,
  output logic        fb_rd,
  input  logic [15:0] fb_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [18:0]   addr_cnt;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic          line_end;
  logic          frame_end;

  logic [RD_LAT-1:0] act_sr;
  logic [RD_LAT-1:0] hs_sr;
  logic [RD_LAT-1:0] vs_sr;

  logic unused_fb_bits;
  assign unused_fb_bits = ^{fb_data[11], fb_data[6:5], fb_data[0]};

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // Counters sit at (0,0) during reset; gating with rstn keeps fb_rd and frame_start
  // low until release, so the first post-reset cycle is pixel (0,0) with its pulse.
  assign active      = rstn && (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = rstn && (h_cnt == '0) && (v_cnt == '0);
  assign vblank      = (v_cnt >= V_VIS);
  assign hs_raw      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw      = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  assign fb_addr = addr_cnt;
  assign fb_rd   = active;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr_cnt <= '0;
    end else begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end

      if (frame_end)   addr_cnt <= '0;
      else if (active) addr_cnt <= addr_cnt + 19'd1;
    end
  end

  // Delay line matching the framebuffer read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_sr <= '0;
      hs_sr  <= '1;
      vs_sr  <= '1;
    end else begin
      act_sr[0] <= active;
      hs_sr[0]  <= hs_raw;
      vs_sr[0]  <= vs_raw;
      for (int i = 1; i < RD_LAT; i++) begin
        act_sr[i] <= act_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
      end
    end
  end

  // Output register; fb_data is only sampled when the delayed active bit says it is real.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_de <= 1'b0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_de <= act_sr[RD_LAT-1];
      vga_hs <= hs_sr[RD_LAT-1];
      vga_vs <= vs_sr[RD_LAT-1];
      if (act_sr[RD_LAT-1]) begin
        vga_r <= fb_data[15:12];
        vga_g <= fb_data[10:7];
        vga_b <= fb_data[4:1];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule
